ps2_kbd_ctrl: RTL and testbench



---
 rtl/ps2_kbd_ctrl.sv | 163 ++++++++++++++++
 tb/tb_ps2_kbd_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard front end: byte handshake, E0/F0 prefix folding, status filtering, event FIFO.
// Optional: define PS2_TYPEMATIC_FILTER_EN to suppress repeated make codes of the held key.
`timescale 1ns/1ps
module ps2_kbd_ctrl #(
    parameter int FIFO_AW = 3
) (
    input  logic       clk,
    input  logic       n_res,
    input  logic       ps2_done,
    input  logic [7:0] ps2_out,
    output logic       ps2_ack,
    input  logic       cpu_rd,
    input  logic       cpu_clr,
    output logic [7:0] kbd_code,
    output logic       kbd_ext,
    output logic       kbd_brk,
    output logic       kbd_valid,
    output logic       kbd_ovf,
    output logic       kbd_err
);

    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {S_IDLE, S_PROC, S_WAIT} state_t;

    state_t     state, state_nx;
    logic [7:0] byte_r;
    logic       ext_r, brk_r;

    logic [FIFO_AW:0] wr_ptr, rd_ptr;
    logic [9:0]       mem [DEPTH];
    logic [9:0]       head;
    logic             empty, full, do_pop, do_push;

    logic is_proc, is_e0, is_f0, is_err_byte, is_status, event_ok, keep, push_req;

    always_ff @(posedge clk or negedge n_res) begin
        if (!n_res) begin
            state  <= S_IDLE;
            byte_r <= 8'h00;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && ps2_done)
                byte_r <= ps2_out;
        end
    end

    // Ack is decoded from state so an asynchronous reset drops it at once.
    always_comb begin
        state_nx = state;
        ps2_ack  = 1'b0;
        case (state)
            S_IDLE: if (ps2_done) state_nx = S_PROC;
            S_PROC: begin
                ps2_ack  = 1'b1;
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                ps2_ack = 1'b1;
                if (!ps2_done) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        is_proc     = (state == S_PROC);
        is_e0       = (byte_r == 8'hE0);
        is_f0       = (byte_r == 8'hF0);
        is_err_byte = (byte_r == 8'h00) || (byte_r == 8'hFF);
        // 0xAA after a prefix is the break code of a real key, not the BAT result.
        is_status   = (byte_r inside {8'hFA, 8'hFE, 8'hEE, 8'hFC}) ||
                      (byte_r == 8'hAA && !ext_r && !brk_r);
        event_ok    = !is_e0 && !is_f0 && !is_err_byte && !is_status;
        push_req    = is_proc && event_ok && keep;
    end

    always_ff @(posedge clk or negedge n_res) begin
        if (!n_res) begin
            ext_r <= 1'b0;
            brk_r <= 1'b0;
        end else if (is_proc) begin
            if (is_e0)
                ext_r <= 1'b1;
            else if (is_f0)
                brk_r <= 1'b1;
            else if (is_err_byte || event_ok) begin
                ext_r <= 1'b0;
                brk_r <= 1'b0;
            end
        end
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic       lm_valid;
    logic [8:0] lm_key;
    logic       lm_hit;

    always_comb begin
        lm_hit = lm_valid && (lm_key == {ext_r, byte_r});
        keep   = brk_r || !lm_hit;
    end

    always_ff @(posedge clk or negedge n_res) begin
        if (!n_res) begin
            lm_valid <= 1'b0;
            lm_key   <= 9'd0;
        end else if (cpu_clr) begin
            lm_valid <= 1'b0;
        end else if (is_proc && event_ok) begin
            if (brk_r) begin
                if (lm_hit) lm_valid <= 1'b0;
            end else if (!lm_hit) begin
                lm_valid <= 1'b1;
                lm_key   <= {ext_r, byte_r};
            end
        end
    end
`else
    assign keep = 1'b1;
`endif

    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                  (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
        do_pop  = cpu_rd && !empty;
        do_push = push_req && (!full || do_pop) && !cpu_clr;
    end

    always_ff @(posedge clk or negedge n_res) begin
        if (!n_res) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            kbd_ovf <= 1'b0;
            kbd_err <= 1'b0;
        end else if (cpu_clr) begin
            rd_ptr  <= wr_ptr;
            kbd_ovf <= 1'b0;
            kbd_err <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push_req && full && !do_pop) kbd_ovf <= 1'b1;
            if (is_proc && is_err_byte)      kbd_err <= 1'b1;
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[FIFO_AW-1:0]] <= {brk_r, ext_r, byte_r};
    end

    always_comb begin
        head      = mem[rd_ptr[FIFO_AW-1:0]];
        kbd_valid = !empty;
        kbd_code  = empty ? 8'h00 : head[7:0];
        kbd_ext   = empty ? 1'b0  : head[8];
        kbd_brk   = empty ? 1'b0  : head[9];
    end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Self-checking bench for ps2_kbd_ctrl: directed scenarios plus randomized bytes vs a queue model.
`timescale 1ns/1ps
module tb_ps2_kbd_ctrl;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       n_res, ps2_done, cpu_rd, cpu_clr, ps2_ack;
    logic [7:0] ps2_out, kbd_code;
    logic       kbd_ext, kbd_brk, kbd_valid, kbd_ovf, kbd_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queue of {brk, ext, code} events and the sticky/prefix flags.
    logic [9:0] q[$];
    bit         m_ovf, m_err, m_ext, m_brk, m_lm_valid;
    logic [8:0] m_lm;

    ps2_kbd_ctrl #(.FIFO_AW(3)) dut (
        .clk(clk), .n_res(n_res), .ps2_done(ps2_done), .ps2_out(ps2_out), .ps2_ack(ps2_ack),
        .cpu_rd(cpu_rd), .cpu_clr(cpu_clr), .kbd_code(kbd_code), .kbd_ext(kbd_ext),
        .kbd_brk(kbd_brk), .kbd_valid(kbd_valid), .kbd_ovf(kbd_ovf), .kbd_err(kbd_err)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        q.delete();
        m_ovf = 0; m_err = 0; m_ext = 0; m_brk = 0; m_lm_valid = 0; m_lm = '0;
    endfunction

    function automatic void model_pop();
        if (q.size() > 0) void'(q.pop_front());
    endfunction

    function automatic void model_clr();
        q.delete();
        m_ovf = 0; m_err = 0; m_lm_valid = 0;
    endfunction

    // mode: 0 = byte alone, 1 = CPU pop in the same cycle as the decode, 2 = cpu_clr in that cycle
    function automatic void model_byte(input logic [7:0] b, input int mode);
        bit keep;
        if (mode == 1) model_pop();
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else if (b == 8'h00 || b == 8'hFF) begin
            m_err = 1; m_ext = 0; m_brk = 0;
        end else if (b == 8'hFA || b == 8'hFE || b == 8'hEE || b == 8'hFC ||
                     (b == 8'hAA && !m_ext && !m_brk)) begin
        end else begin
            keep = 1;
`ifdef PS2_TYPEMATIC_FILTER_EN
            if (m_brk) begin
                if (m_lm_valid && m_lm == {m_ext, b}) m_lm_valid = 0;
            end else if (m_lm_valid && m_lm == {m_ext, b}) begin
                keep = 0;
            end else begin
                m_lm_valid = 1; m_lm = {m_ext, b};
            end
`endif
            if (keep) begin
                if (q.size() < DEPTH) q.push_back({m_brk, m_ext, b});
                else m_ovf = 1;
            end
            m_ext = 0; m_brk = 0;
        end
        if (mode == 2) model_clr();
    endfunction

    function automatic logic [10:0] exp_head();
        if (q.size() > 0) return {1'b1, q[0]};
        return 11'd0;
    endfunction

    // Drives one receiver byte through the done/ack handshake; checks ack timing and latency.
    task automatic send_byte(input logic [7:0] b, input int hold, input int mode);
        @(negedge clk);
        n_checks++;
        if (ps2_ack !== 1'b0) begin n_fail++; $display("FAIL ack_idle: got %b, expected 0", ps2_ack); end
        ps2_out  = b;
        ps2_done = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ps2_ack !== 1'b1) begin n_fail++; $display("FAIL ack_rise: got %b, expected 1", ps2_ack); end
        n_checks++;
        if (kbd_valid !== (q.size() > 0)) begin
            n_fail++; $display("FAIL valid_early: got %b, expected %b", kbd_valid, q.size() > 0);
        end
        cpu_rd  = (mode == 1);
        cpu_clr = (mode == 2);
        @(negedge clk);
        cpu_rd  = 1'b0;
        cpu_clr = 1'b0;
        model_byte(b, mode);
        n_checks++;
        if (kbd_valid !== (q.size() > 0)) begin
            n_fail++; $display("FAIL valid_latency: got %b, expected %b", kbd_valid, q.size() > 0);
        end
        repeat (hold - 2) @(negedge clk);
        n_checks++;
        if (ps2_ack !== 1'b1) begin n_fail++; $display("FAIL ack_hold: got %b, expected 1", ps2_ack); end
        ps2_done = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ps2_ack !== 1'b0) begin n_fail++; $display("FAIL ack_fall: got %b, expected 0", ps2_ack); end
    endtask

    task automatic pop_cycle();
        @(negedge clk);
        cpu_rd = 1'b1;
        @(negedge clk);
        cpu_rd = 1'b0;
        model_pop();
    endtask

    task automatic clr_cycle();
        @(negedge clk);
        cpu_clr = 1'b1;
        @(negedge clk);
        cpu_clr = 1'b0;
        model_clr();
    endtask

    task automatic test_reset();
        n_res = 1'b0; ps2_done = 1'b0; ps2_out = 8'h00; cpu_rd = 1'b0; cpu_clr = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({ps2_ack, kbd_valid, kbd_ovf, kbd_err, kbd_brk, kbd_ext, kbd_code} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, expected 0",
                     {ps2_ack, kbd_valid, kbd_ovf, kbd_err, kbd_brk, kbd_ext, kbd_code});
        end
        n_res = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_make_break();
        send_byte(8'h1C, 40, 0);
        send_byte(8'hF0, 40, 0);
        send_byte(8'h1C, 40, 0);
        n_checks++;
        if ({kbd_valid, kbd_brk, kbd_ext, kbd_code} !== {3'b100, 8'h1C}) begin
            n_fail++; $display("FAIL make_1c: got %h, expected %h", {kbd_valid, kbd_brk, kbd_ext, kbd_code}, {3'b100, 8'h1C});
        end
        pop_cycle();
        n_checks++;
        if ({kbd_valid, kbd_brk, kbd_ext, kbd_code} !== {3'b110, 8'h1C}) begin
            n_fail++; $display("FAIL break_1c: got %h, expected %h", {kbd_valid, kbd_brk, kbd_ext, kbd_code}, {3'b110, 8'h1C});
        end
        pop_cycle();
        n_checks++;
        if (kbd_valid !== 1'b0) begin n_fail++; $display("FAIL mb_empty: got %b, expected 0", kbd_valid); end
    endtask

    task automatic test_prefixes();
        send_byte(8'hE0, 3, 0);
        send_byte(8'hF0, 3, 0);
        send_byte(8'h75, 3, 0);
        send_byte(8'h75, 3, 0);
        n_checks++;
        if ({kbd_valid, kbd_brk, kbd_ext, kbd_code} !== {3'b111, 8'h75}) begin
            n_fail++; $display("FAIL ext_break_75: got %h, expected %h", {kbd_valid, kbd_brk, kbd_ext, kbd_code}, {3'b111, 8'h75});
        end
        pop_cycle();
        n_checks++;
        if ({kbd_valid, kbd_brk, kbd_ext, kbd_code} !== {3'b100, 8'h75}) begin
            n_fail++; $display("FAIL prefix_cleared: got %h, expected %h", {kbd_valid, kbd_brk, kbd_ext, kbd_code}, {3'b100, 8'h75});
        end
        pop_cycle();
    endtask

    task automatic test_status_filter();
        send_byte(8'hAA, 3, 0);
        send_byte(8'hFA, 3, 0);
        send_byte(8'hF0, 3, 0);
        send_byte(8'hAA, 3, 0);
        n_checks++;
        if ({kbd_valid, kbd_brk, kbd_ext, kbd_code} !== {3'b110, 8'hAA}) begin
            n_fail++; $display("FAIL break_aa: got %h, expected %h", {kbd_valid, kbd_brk, kbd_ext, kbd_code}, {3'b110, 8'hAA});
        end
        pop_cycle();
        send_byte(8'h00, 3, 0);
        n_checks++;
        if ({kbd_valid, kbd_err} !== 2'b01) begin
            n_fail++; $display("FAIL err_set: got %b, expected 01", {kbd_valid, kbd_err});
        end
        clr_cycle();
        n_checks++;
        if (kbd_err !== 1'b0) begin n_fail++; $display("FAIL err_clr: got %b, expected 0", kbd_err); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 9; i++) send_byte(8'(i), 2, 0);
        n_checks++;
        if ({kbd_ovf, kbd_valid, kbd_code} !== {2'b11, 8'h01}) begin
            n_fail++; $display("FAIL ovf_set: got %h, expected %h", {kbd_ovf, kbd_valid, kbd_code}, {2'b11, 8'h01});
        end
        for (int i = 1; i <= 8; i++) begin
            n_checks++;
            if ({kbd_valid, kbd_code} !== {1'b1, 8'(i)}) begin
                n_fail++; $display("FAIL ovf_drain: got %h, expected %h", {kbd_valid, kbd_code}, {1'b1, 8'(i)});
            end
            pop_cycle();
        end
        n_checks++;
        if (kbd_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got %b, expected 0", kbd_valid); end
        pop_cycle();
        send_byte(8'h33, 2, 0);
        n_checks++;
        if ({kbd_valid, kbd_code} !== {1'b1, 8'h33}) begin
            n_fail++; $display("FAIL pop_empty_ignored: got %h, expected %h", {kbd_valid, kbd_code}, {1'b1, 8'h33});
        end
        pop_cycle();
        n_checks++;
        if (kbd_valid !== 1'b0) begin n_fail++; $display("FAIL single_empty: got %b, expected 0", kbd_valid); end
        clr_cycle();
        n_checks++;
        if (kbd_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b, expected 0", kbd_ovf); end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), 2, 0);
        send_byte(8'h18, 2, 1);
        n_checks++;
        if ({kbd_ovf, kbd_valid, kbd_code} !== {2'b01, 8'h11}) begin
            n_fail++; $display("FAIL full_pushpop: got %h, expected %h", {kbd_ovf, kbd_valid, kbd_code}, {2'b01, 8'h11});
        end
        for (int i = 1; i <= 8; i++) begin
            n_checks++;
            if ({kbd_valid, kbd_code} !== {1'b1, 8'h10 + 8'(i)}) begin
                n_fail++; $display("FAIL full_drain: got %h, expected %h", {kbd_valid, kbd_code}, {1'b1, 8'h10 + 8'(i)});
            end
            pop_cycle();
        end
        n_checks++;
        if (kbd_valid !== 1'b0) begin n_fail++; $display("FAIL full_empty: got %b, expected 0", kbd_valid); end
    endtask

    task automatic test_clr_wins();
        send_byte(8'h44, 2, 2);
        n_checks++;
        if (kbd_valid !== 1'b0) begin n_fail++; $display("FAIL clr_wins: got %b, expected 0", kbd_valid); end
    endtask

    task automatic test_reset_midshake();
        send_byte(8'hF0, 2, 0);
        @(negedge clk);
        ps2_out = 8'h2A; ps2_done = 1'b1;
        repeat (2) @(negedge clk);
        #1 n_res = 1'b0;
        #1;
        n_checks++;
        if (ps2_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b, expected 0", ps2_ack); end
        ps2_done = 1'b0;
        model_reset();
        @(negedge clk);
        n_res = 1'b1;
        send_byte(8'h2A, 2, 0);
        n_checks++;
        if ({kbd_valid, kbd_brk, kbd_ext, kbd_code} !== {3'b100, 8'h2A}) begin
            n_fail++; $display("FAIL reset_prefix_lost: got %h, expected %h", {kbd_valid, kbd_brk, kbd_ext, kbd_code}, {3'b100, 8'h2A});
        end
        pop_cycle();
    endtask

    task automatic test_typematic();
        logic [7:0] seq [6] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
        int n_ev = 0;
        int exp_n;
        clr_cycle();
        foreach (seq[i]) send_byte(seq[i], 2, 0);
`ifdef PS2_TYPEMATIC_FILTER_EN
        exp_n = 3;
`else
        exp_n = 5;
`endif
        for (int i = 0; i < 10 && kbd_valid === 1'b1; i++) begin
            n_checks++;
            if ({kbd_valid, kbd_brk, kbd_ext, kbd_code} !== exp_head()) begin
                n_fail++; $display("FAIL typematic_event: got %h, expected %h", {kbd_valid, kbd_brk, kbd_ext, kbd_code}, exp_head());
            end
            n_ev++;
            pop_cycle();
        end
        n_checks++;
        if (n_ev !== exp_n) begin n_fail++; $display("FAIL typematic_count: got %0d, expected %0d", n_ev, exp_n); end
    endtask

    task automatic test_random();
        logic [7:0] specials [7] = '{8'hFA, 8'hFE, 8'hEE, 8'hFC, 8'hAA, 8'h00, 8'hFF};
        logic [7:0] b;
        int         sel, mode;
        for (int it = 0; it < 120; it++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 8'hE0;
            else if (sel == 1) b = 8'hF0;
            else if (sel == 2) b = specials[$urandom_range(0, 6)];
            else if (sel < 6) b = 8'h10 + 8'($urandom_range(0, 3));
            else b = 8'($urandom_range(0, 255));
            mode = $urandom_range(0, 19);
            mode = (mode == 0) ? 2 : (mode < 6) ? 1 : 0;
            send_byte(b, $urandom_range(2, 6), mode);
            if ($urandom_range(0, 3) == 0) pop_cycle();
            if ($urandom_range(0, 29) == 0) clr_cycle();
            n_checks++;
            if ({kbd_ovf, kbd_err, kbd_valid, kbd_brk, kbd_ext, kbd_code} !== {m_ovf, m_err, exp_head()}) begin
                n_fail++;
                $display("FAIL random_state: got %h, expected %h (byte %h)",
                         {kbd_ovf, kbd_err, kbd_valid, kbd_brk, kbd_ext, kbd_code}, {m_ovf, m_err, exp_head()}, b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_prefixes();
        test_status_filter();
        test_overflow();
        test_full_push_pop();
        test_clr_wins();
        test_reset_midshake();
        test_typematic();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
